// File: rtl/trap_ctrl_u_if.sv
// ============================================================================
// Module   : trap_ctrl_u_if
// Purpose  : Bus bundle between exception control, CSR port, fetch and the
//            trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_ctrl_u_if;
    logic [1:0]  exception_cause;
    logic [31:0] exception_epc;
    logic [31:0] exception_tval;
    logic        mret;
    logic        redirect_ready;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;

    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] trap_count;

    modport master (
        output exception_cause, exception_epc, exception_tval, mret,
               redirect_ready, csr_we, csr_addr, csr_wdata,
        input  stall, flush, redirect_valid, redirect_pc, busy,
               mtvec, mepc, mcause, mtval, trap_count
    );

    modport slave (
        input  exception_cause, exception_epc, exception_tval, mret,
               redirect_ready, csr_we, csr_addr, csr_wdata,
        output stall, flush, redirect_valid, redirect_pc, busy,
               mtvec, mepc, mcause, mtval, trap_count
    );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl_u.sv
// ============================================================================
// Module   : trap_ctrl_u
// Purpose  : Trap/MRET sequencer: flush, trap-CSR capture, PC redirect.
//            Optional macro TRAP_COUNTER_EN enables the trap_count counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl_u #(
    parameter logic [1:0]  NOT_EXCEPTION       = 2'b00,
    parameter logic [1:0]  I_ADDR_MISALIGNMENT = 2'b01,
    parameter logic [1:0]  ILLEGAL_IR          = 2'b10,
    parameter int          FLUSH_CYCLES        = 2,
    parameter logic [31:0] RESET_MTVEC         = 32'h0001_0000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    trap_ctrl_u_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0]  C_FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [11:0] C_ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] C_ADDR_MEPC   = 12'h341;
    localparam logic [11:0] C_ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] C_ADDR_MTVAL  = 12'h343;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [31:0] target;
    logic        stall_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        busy_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;

    logic        exc_take;
    logic        mret_take;

    // Encoding 2'b11 is not a real cause and behaves like NOT_EXCEPTION.
    assign exc_take  = (state == IDLE) &&
                       ((bus.exception_cause == I_ADDR_MISALIGNMENT) ||
                        (bus.exception_cause == ILLEGAL_IR));
    assign mret_take = (state == IDLE) && bus.mret && !exc_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            flush_cnt        <= 4'd0;
            target           <= 32'd0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            busy_q           <= 1'b0;
            mtvec_q          <= RESET_MTVEC;
            mepc_q           <= 32'd0;
            mcause_q         <= 32'd0;
            mtval_q          <= 32'd0;
        end else begin
            if (bus.csr_we) begin
                case (bus.csr_addr)
                    C_ADDR_MTVEC:  mtvec_q  <= {bus.csr_wdata[31:2], 2'b00};
                    C_ADDR_MEPC:   mepc_q   <= {bus.csr_wdata[31:2], 2'b00};
                    C_ADDR_MCAUSE: mcause_q <= bus.csr_wdata;
                    C_ADDR_MTVAL:  mtval_q  <= bus.csr_wdata;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (exc_take || mret_take) begin
                        state     <= FLUSH;
                        flush_cnt <= C_FLUSH_LOAD;
                        flush_q   <= 1'b1;
                        stall_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                    // Later assignments override a same-cycle CSR write; target
                    // sees the pre-write mtvec.
                    if (exc_take) begin
                        target   <= mtvec_q;
                        mepc_q   <= {bus.exception_epc[31:2], 2'b00};
                        mtval_q  <= bus.exception_tval;
                        mcause_q <= (bus.exception_cause == ILLEGAL_IR) ? 32'd2 : 32'd0;
                    end else if (mret_take) begin
                        target   <= mepc_q;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state            <= REDIRECT;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state            <= IDLE;
                        redirect_valid_q <= 1'b0;
                        stall_q          <= 1'b0;
                        busy_q           <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    flush_q          <= 1'b0;
                    stall_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRAP_COUNTER_EN
    logic [31:0] trap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_cnt <= 32'd0;
        end else if (exc_take) begin
            trap_cnt <= trap_cnt + 32'd1;
        end
    end

    assign bus.trap_count = trap_cnt;
`else
    assign bus.trap_count = 32'd0;
`endif

    assign bus.stall          = stall_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = busy_q;
    assign bus.mtvec          = mtvec_q;
    assign bus.mepc           = mepc_q;
    assign bus.mcause         = mcause_q;
    assign bus.mtval          = mtval_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl_u.sv
// ============================================================================
// Module   : tb_trap_ctrl_u
// Purpose  : Vector-table and directed-sequence bench for trap_ctrl_u.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl_u;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [31:0] exp_cnt;

    trap_ctrl_u_if bus ();

    trap_ctrl_u dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        mret;
        logic        evt;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mtval;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.exception_cause = 2'b00;
        bus.exception_epc   = 32'd0;
        bus.exception_tval  = 32'd0;
        bus.mret            = 1'b0;
        bus.csr_we          = 1'b0;
        bus.csr_addr        = 12'd0;
        bus.csr_wdata       = 32'd0;
    endtask

    task automatic chk_csrs(input string tag, input logic [31:0] mc, input logic [31:0] me,
                            input logic [31:0] mv, input logic [31:0] mt);
        chk({tag, " mcause"}, bus.mcause, mc);
        chk({tag, " mepc"},   bus.mepc,   me);
        chk({tag, " mtval"},  bus.mtval,  mv);
        chk({tag, " mtvec"},  bus.mtvec,  mt);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        exp_cnt = 32'd0;
        rst     = 1'b1;
        bus.redirect_ready = 1'b1;
        clear_inputs();

        //         we    addr     wdata         cause  epc           tval          mret evt   mcause  mepc          mtval         mtvec         pc
        vecs[0] = '{1'b0, 12'h000, 32'h0,        2'b10, 32'h0001_0040, 32'h0000_FFFF, 1'b0, 1'b1, 32'd2,  32'h0001_0040, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_0000};
        vecs[1] = '{1'b1, 12'h305, 32'h0002_0003, 2'b01, 32'h0001_0006, 32'h0001_0006, 1'b0, 1'b1, 32'd0,  32'h0001_0004, 32'h0001_0006, 32'h0002_0000, 32'h0002_0000};
        vecs[2] = '{1'b0, 12'h000, 32'h0,        2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'd0,  32'h0001_0004, 32'h0001_0006, 32'h0002_0000, 32'h0001_0004};
        vecs[3] = '{1'b0, 12'h000, 32'h0,        2'b10, 32'h0003_0008, 32'h1234_5678, 1'b1, 1'b1, 32'd2,  32'h0003_0008, 32'h1234_5678, 32'h0002_0000, 32'h0002_0000};
        vecs[4] = '{1'b0, 12'h000, 32'h0,        2'b11, 32'h0009_0000, 32'h5555_0000, 1'b0, 1'b0, 32'd2,  32'h0003_0008, 32'h1234_5678, 32'h0002_0000, 32'h0};
        vecs[5] = '{1'b1, 12'h341, 32'h0004_0007, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'd2,  32'h0004_0004, 32'h1234_5678, 32'h0002_0000, 32'h0004_0004};
        vecs[6] = '{1'b1, 12'h342, 32'h0000_000B, 2'b11, 32'h0,         32'h0,         1'b0, 1'b0, 32'hB,  32'h0004_0004, 32'h1234_5678, 32'h0002_0000, 32'h0};
        vecs[7] = '{1'b1, 12'h7FF, 32'hDEAD_BEEF, 2'b01, 32'h0005_0002, 32'hAAAA_5555, 1'b0, 1'b1, 32'd0,  32'h0005_0000, 32'hAAAA_5555, 32'h0002_0000, 32'h0002_0000};

        step();
        step();
        chk("reset stall",          {31'd0, bus.stall},          32'd0);
        chk("reset flush",          {31'd0, bus.flush},          32'd0);
        chk("reset redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("reset busy",           {31'd0, bus.busy},           32'd0);
        chk("reset redirect_pc",    bus.redirect_pc,             32'd0);
        chk("reset trap_count",     bus.trap_count,              32'd0);
        chk_csrs("reset", 32'd0, 32'd0, 32'd0, 32'h0001_0000);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) begin
                bus.csr_we    = 1'b1;
                bus.csr_addr  = vecs[i].addr;
                bus.csr_wdata = vecs[i].wdata;
                step();
                clear_inputs();
            end
            bus.exception_cause = vecs[i].cause;
            bus.exception_epc   = vecs[i].epc;
            bus.exception_tval  = vecs[i].tval;
            bus.mret            = vecs[i].mret;
            step();
            clear_inputs();
            if (vecs[i].cause == 2'b01 || vecs[i].cause == 2'b10)
                exp_cnt++;
            if (vecs[i].evt) begin
                chk($sformatf("v%0d flush T+1", i), {31'd0, bus.flush}, 32'd1);
                chk($sformatf("v%0d stall T+1", i), {31'd0, bus.stall}, 32'd1);
                chk($sformatf("v%0d busy T+1", i),  {31'd0, bus.busy},  32'd1);
                chk($sformatf("v%0d valid T+1", i), {31'd0, bus.redirect_valid}, 32'd0);
                step();
                chk($sformatf("v%0d flush T+2", i), {31'd0, bus.flush}, 32'd1);
                step();
                chk($sformatf("v%0d flush T+3", i), {31'd0, bus.flush}, 32'd0);
                chk($sformatf("v%0d valid T+3", i), {31'd0, bus.redirect_valid}, 32'd1);
                chk($sformatf("v%0d stall T+3", i), {31'd0, bus.stall}, 32'd1);
                chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vecs[i].exp_pc);
                step();
                chk($sformatf("v%0d valid T+4", i), {31'd0, bus.redirect_valid}, 32'd0);
            end
            chk($sformatf("v%0d busy end", i), {31'd0, bus.busy}, 32'd0);
            chk_csrs($sformatf("v%0d", i), vecs[i].exp_mcause, vecs[i].exp_mepc,
                     vecs[i].exp_mtval, vecs[i].exp_mtvec);
`ifdef TRAP_COUNTER_EN
            chk($sformatf("v%0d trap_count", i), bus.trap_count, exp_cnt);
`else
            chk($sformatf("v%0d trap_count", i), bus.trap_count, 32'd0);
`endif
        end

        // MRET with fetch back-pressured for three redirect cycles.
        bus.redirect_ready = 1'b0;
        bus.mret = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold valid %0d", k), {31'd0, bus.redirect_valid}, 32'd1);
            chk($sformatf("hold pc %0d", k), bus.redirect_pc, 32'h0005_0000);
            step();
        end
        chk("hold valid 3", {31'd0, bus.redirect_valid}, 32'd1);
        bus.redirect_ready = 1'b1;
        step();
        chk("hold release busy",  {31'd0, bus.busy},           32'd0);
        chk("hold release valid", {31'd0, bus.redirect_valid}, 32'd0);

        // A cause pulsed while busy must be ignored.
        bus.redirect_ready  = 1'b0;
        bus.exception_cause = 2'b01;
        bus.exception_epc   = 32'h0007_0000;
        bus.exception_tval  = 32'h0000_0077;
        step();
        exp_cnt++;
        bus.exception_cause = 2'b10;
        bus.exception_epc   = 32'h0009_9990;
        bus.exception_tval  = 32'h0000_9999;
        step();
        step();
        step();
        chk_csrs("busy ignore", 32'd0, 32'h0007_0000, 32'h0000_0077, 32'h0002_0000);
        chk("busy ignore busy", {31'd0, bus.busy}, 32'd1);
        clear_inputs();
        bus.redirect_ready = 1'b1;
        step();
        step();
        chk("busy ignore idle", {31'd0, bus.busy}, 32'd0);
        chk_csrs("busy ignore after", 32'd0, 32'h0007_0000, 32'h0000_0077, 32'h0002_0000);

        // CSR writes colliding with a trap capture.
        bus.exception_cause = 2'b10;
        bus.exception_epc   = 32'h0008_0000;
        bus.exception_tval  = 32'h0000_0001;
        bus.csr_we          = 1'b1;
        bus.csr_addr        = 12'h305;
        bus.csr_wdata       = 32'h0006_0001;
        step();
        clear_inputs();
        exp_cnt++;
        chk("collide mtvec", bus.mtvec, 32'h0006_0000);
        step();
        step();
        chk("collide old target", bus.redirect_pc, 32'h0002_0000);
        step();
        bus.exception_cause = 2'b01;
        bus.exception_epc   = 32'h0009_0000;
        bus.exception_tval  = 32'h0000_0002;
        bus.csr_we          = 1'b1;
        bus.csr_addr        = 12'h341;
        bus.csr_wdata       = 32'h1111_0000;
        step();
        clear_inputs();
        exp_cnt++;
        chk("collide mepc", bus.mepc, 32'h0009_0000);
        step();
        step();
        chk("collide new target", bus.redirect_pc, 32'h0006_0000);
        step();
`ifdef TRAP_COUNTER_EN
        chk("trap_count total", bus.trap_count, exp_cnt);
`else
        chk("trap_count total", bus.trap_count, 32'd0);
`endif

        // Reset in the middle of a flush abandons the trap.
        bus.exception_cause = 2'b10;
        bus.exception_epc   = 32'h000A_0000;
        bus.exception_tval  = 32'h0000_0003;
        step();
        clear_inputs();
        chk("pre-rst flush", {31'd0, bus.flush}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst flush",       {31'd0, bus.flush},          32'd0);
        chk("rst stall",       {31'd0, bus.stall},          32'd0);
        chk("rst busy",        {31'd0, bus.busy},           32'd0);
        chk("rst valid",       {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst redirect_pc", bus.redirect_pc,             32'd0);
        chk("rst trap_count",  bus.trap_count,              32'd0);
        chk_csrs("rst", 32'd0, 32'd0, 32'd0, 32'h0001_0000);
        step();
        step();
        step();
        chk("rst stays idle", {31'd0, bus.redirect_valid | bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
